// File: rtl/sensor_req_pkg.sv
// sensor_req_pkg: shared command codes, response bytes, frame layout and FSM states
package sensor_req_pkg;

    localparam logic [7:0] CMD_STATUS   = 8'h03;
    localparam logic [7:0] CMD_TEMP     = 8'h04;
    localparam logic [7:0] CMD_HUM      = 8'h05;
    localparam logic [7:0] CMD_STREAM_T = 8'h06;
    localparam logic [7:0] CMD_STREAM_H = 8'h07;
    localparam logic [7:0] CMD_STOP     = 8'h08;

    localparam logic [7:0] HDR_BAD_ADDR   = 8'hEF;
    localparam logic [7:0] HDR_BAD_CMD    = 8'hCF;
    localparam logic [7:0] PAY_STATUS_OK  = 8'h00;
    localparam logic [7:0] PAY_STATUS_BAD = 8'h1F;
    localparam logic [7:0] PAY_BAD_CRC    = 8'hFF;

    localparam int OFF_HUM_INT  = 32;
    localparam int OFF_HUM_FLT  = 24;
    localparam int OFF_TEMP_INT = 16;
    localparam int OFF_TEMP_FLT = 8;
    localparam int OFF_CRC      = 0;

    typedef enum logic {P_IDLE, P_WAIT_CMD} parse_state_t;

    typedef enum logic [2:0] {
        T_IDLE, T_LOAD, T_SEND_HDR, T_WAIT_HDR, T_SEND_PAY, T_WAIT_PAY
    } tx_state_t;

    // Checksum is the byte-wide sum of the four data fields
    function automatic logic frame_crc_ok(input logic [39:0] f);
        return 8'(f[OFF_HUM_INT+:8] + f[OFF_HUM_FLT+:8] + f[OFF_TEMP_INT+:8] + f[OFF_TEMP_FLT+:8]) == f[OFF_CRC+:8];
    endfunction

endpackage

// File: rtl/sensor_frame_buf.sv
// sensor_frame_buf: latest frame per channel with valid flags, CRC check and read mux
module sensor_frame_buf import sensor_req_pkg::*; #(
    parameter int N_CH = 4
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [40*N_CH-1:0]  sens_frame_i,
    input  logic [N_CH-1:0]     sens_valid_i,
    input  logic [7:0]          rd_ch_i,
    output logic [7:0]          rd_temp_o,
    output logic [7:0]          rd_hum_o,
    output logic                rd_crc_ok_o
);

    logic [39:0]     frame_q [N_CH];
    logic [N_CH-1:0] valid_q;

    // Frame storage needs no reset; the valid flags guard it
    always_ff @(posedge clock_i) begin
        for (int c = 0; c < N_CH; c++)
            if (sens_valid_i[c]) frame_q[c] <= sens_frame_i[40*c +: 40];
    end

    // A channel becomes valid on its first update and stays valid until reset
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) valid_q <= '0;
        else         valid_q <= valid_q | sens_valid_i;
    end

    // Compare-based mux keeps out-of-range channel numbers harmless
    always_comb begin
        rd_temp_o   = '0;
        rd_hum_o    = '0;
        rd_crc_ok_o = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_ch_i == 8'(c)) begin
                rd_temp_o   = frame_q[c][OFF_TEMP_INT+:8];
                rd_hum_o    = frame_q[c][OFF_HUM_INT+:8];
                rd_crc_ok_o = valid_q[c] && frame_crc_ok(frame_q[c]);
            end
        end
    end

endmodule

// File: rtl/sensor_req_ctrl.sv
// sensor_req_ctrl: UART request parser, per-channel frame responder and periodic streamer
module sensor_req_ctrl import sensor_req_pkg::*; #(
    parameter int N_CH           = 4,
    parameter int PERIOD_CYC     = 100_000_000,
    parameter int RX_TIMEOUT_CYC = 5_000_000
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                rx_valid_i,
    input  logic [7:0]          rx_data_i,
    input  logic                tx_busy_i,
    output logic                tx_start_o,
    output logic [7:0]          tx_data_o,
    input  logic [40*N_CH-1:0]  sens_frame_i,
    input  logic [N_CH-1:0]     sens_valid_i,
    output logic                stream_on_o,
    output logic                overrun_o
);

    localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CYC - 1);
    localparam logic [31:0] TMO_LAST    = 32'(RX_TIMEOUT_CYC - 1);

    parse_state_t p_q, p_d;
    tx_state_t    t_q, t_d;
    logic [7:0]   addr_q, addr_d;
    logic [31:0]  to_q, to_d;
    logic         push;
    logic         pend_v_q, pend_v_d;
    logic [15:0]  pend_q, pend_d;
    logic         overrun_q, overrun_d;
    logic [7:0]   tx_data_q, tx_data_d, pay_q, pay_d;
    logic         skip_q, skip_d;
    logic         stream_on_q, stream_on_d, stream_hum_q, stream_hum_d;
    logic [7:0]   stream_ch_q, stream_ch_d;
    logic [31:0]  tcnt_q, tcnt_d;
    logic         tick_q, tick_d;
    logic [7:0]   req_addr, req_cmd, rd_ch, rd_temp, rd_hum, rsp_hdr, rsp_pay;
    logic         rd_ok, addr_ok, load_req, load_tick;

    assign req_addr    = pend_q[15:8];
    assign req_cmd     = pend_q[7:0];
    assign addr_ok     = int'(req_addr) < N_CH;
    assign load_req    = t_q == T_LOAD && pend_v_q;
    assign load_tick   = t_q == T_LOAD && !pend_v_q;
    assign rd_ch       = pend_v_q ? req_addr : stream_ch_q;
    assign tx_data_o   = tx_data_q;
    assign stream_on_o = stream_on_q;
    assign overrun_o   = overrun_q;

    sensor_frame_buf #(.N_CH(N_CH)) u_buf (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .sens_frame_i (sens_frame_i),
        .sens_valid_i (sens_valid_i),
        .rd_ch_i      (rd_ch),
        .rd_temp_o    (rd_temp),
        .rd_hum_o     (rd_hum),
        .rd_crc_ok_o  (rd_ok)
    );

    // Byte-pair parser with an address-to-command timeout, feeding a one-entry pending slot
    always_comb begin
        p_d      = p_q;
        addr_d   = addr_q;
        to_d     = to_q;
        push     = 1'b0;
        case (p_q)
            P_IDLE: if (rx_valid_i) begin
                addr_d = rx_data_i;
                to_d   = '0;
                p_d    = P_WAIT_CMD;
            end
            P_WAIT_CMD: begin
                if (rx_valid_i) begin
                    push = 1'b1;
                    p_d  = P_IDLE;
                end else if (to_q == TMO_LAST) p_d = P_IDLE;
                else to_d = to_q + 32'd1;
            end
        endcase
        pend_v_d  = pend_v_q && !load_req;
        pend_d    = pend_q;
        overrun_d = push && pend_v_d;
        if (push && !pend_v_d) begin
            pend_v_d = 1'b1;
            pend_d   = {addr_q, rx_data_i};
        end
    end

    // Response bytes for whichever source the tx FSM is about to load
    always_comb begin
        rsp_hdr = stream_hum_q ? CMD_STREAM_H : CMD_STREAM_T;
        rsp_pay = !rd_ok ? PAY_BAD_CRC : stream_hum_q ? rd_hum : rd_temp;
        if (pend_v_q) begin
            if (!addr_ok) begin
                rsp_hdr = HDR_BAD_ADDR;
                rsp_pay = req_addr;
            end else begin
                case (req_cmd)
                    CMD_STATUS: begin
                        rsp_hdr = CMD_STATUS;
                        rsp_pay = rd_ok ? PAY_STATUS_OK : PAY_STATUS_BAD;
                    end
                    CMD_TEMP: begin
                        rsp_hdr = CMD_TEMP;
                        rsp_pay = rd_ok ? rd_temp : PAY_BAD_CRC;
                    end
                    CMD_HUM: begin
                        rsp_hdr = CMD_HUM;
                        rsp_pay = rd_ok ? rd_hum : PAY_BAD_CRC;
                    end
                    CMD_STREAM_T, CMD_STREAM_H: begin
                        rsp_hdr = req_cmd;
                        rsp_pay = req_addr;
                    end
                    CMD_STOP: begin
                        rsp_hdr = CMD_STOP;
                        rsp_pay = 8'h00;
                    end
                    default: begin
                        rsp_hdr = HDR_BAD_CMD;
                        rsp_pay = req_cmd;
                    end
                endcase
            end
        end
    end

    // Stream control: period counter, merged tick flag, start/stop on loaded commands
    always_comb begin
        stream_on_d  = stream_on_q;
        stream_ch_d  = stream_ch_q;
        stream_hum_d = stream_hum_q;
        tcnt_d       = tcnt_q;
        tick_d       = tick_q && !load_tick;
        if (stream_on_q) begin
            if (tcnt_q == PERIOD_LAST) begin
                tcnt_d = '0;
                tick_d = 1'b1;
            end else tcnt_d = tcnt_q + 32'd1;
        end
        if (load_req && addr_ok && (req_cmd == CMD_STREAM_T || req_cmd == CMD_STREAM_H)) begin
            stream_on_d  = 1'b1;
            stream_ch_d  = req_addr;
            stream_hum_d = req_cmd == CMD_STREAM_H;
            tcnt_d       = '0;
            tick_d       = 1'b0;
        end else if (load_req && addr_ok && req_cmd == CMD_STOP) begin
            stream_on_d = 1'b0;
            tcnt_d      = '0;
            tick_d      = 1'b0;
        end
    end

    // Tx FSM: snapshot both bytes in LOAD, then hand each to the transmitter when it is free
    always_comb begin
        t_d        = t_q;
        tx_start_o = 1'b0;
        tx_data_d  = tx_data_q;
        pay_d      = pay_q;
        skip_d     = 1'b0;
        case (t_q)
            T_IDLE: if (pend_v_q || tick_q) t_d = T_LOAD;
            T_LOAD: begin
                tx_data_d = rsp_hdr;
                pay_d     = rsp_pay;
                t_d       = T_SEND_HDR;
            end
            T_SEND_HDR: if (!tx_busy_i) begin
                tx_start_o = 1'b1;
                skip_d     = 1'b1;
                t_d        = T_WAIT_HDR;
            end
            T_WAIT_HDR: if (!skip_q && !tx_busy_i) begin
                tx_data_d = pay_q;
                t_d       = T_SEND_PAY;
            end
            T_SEND_PAY: if (!tx_busy_i) begin
                tx_start_o = 1'b1;
                skip_d     = 1'b1;
                t_d        = T_WAIT_PAY;
            end
            T_WAIT_PAY: if (!skip_q && !tx_busy_i) t_d = T_IDLE;
            default: t_d = T_IDLE;
        endcase
    end

    // State registers; reset aborts any transfer in progress
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            p_q          <= P_IDLE;
            addr_q       <= '0;
            to_q         <= '0;
            pend_v_q     <= 1'b0;
            pend_q       <= '0;
            overrun_q    <= 1'b0;
            t_q          <= T_IDLE;
            tx_data_q    <= '0;
            pay_q        <= '0;
            skip_q       <= 1'b0;
            stream_on_q  <= 1'b0;
            stream_ch_q  <= '0;
            stream_hum_q <= 1'b0;
            tcnt_q       <= '0;
            tick_q       <= 1'b0;
        end else begin
            p_q          <= p_d;
            addr_q       <= addr_d;
            to_q         <= to_d;
            pend_v_q     <= pend_v_d;
            pend_q       <= pend_d;
            overrun_q    <= overrun_d;
            t_q          <= t_d;
            tx_data_q    <= tx_data_d;
            pay_q        <= pay_d;
            skip_q       <= skip_d;
            stream_on_q  <= stream_on_d;
            stream_ch_q  <= stream_ch_d;
            stream_hum_q <= stream_hum_d;
            tcnt_q       <= tcnt_d;
            tick_q       <= tick_d;
        end
    end

endmodule

// File: tb/tb_sensor_req_ctrl.sv
// tb_sensor_req_ctrl: table-driven request/response checks plus stream, timeout, overrun and reset sequences
module tb_sensor_req_ctrl;

    localparam int N_CH = 4, PERIOD = 2000, TMO = 300, BYTE_CYC = 10;

    logic               clock = 1'b0, reset = 1'b1, rx_valid = 1'b0, hold = 1'b0;
    logic [7:0]         rx_data = '0, tx_data;
    logic [40*N_CH-1:0] sens_frame = '0;
    logic [N_CH-1:0]    sens_valid = '0;
    logic               tx_busy, tx_start, stream_on, overrun;

    sensor_req_ctrl #(.N_CH(N_CH), .PERIOD_CYC(PERIOD), .RX_TIMEOUT_CYC(TMO)) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .tx_busy_i    (tx_busy),
        .tx_start_o   (tx_start),
        .tx_data_o    (tx_data),
        .sens_frame_i (sens_frame),
        .sens_valid_i (sens_valid),
        .stream_on_o  (stream_on),
        .overrun_o    (overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int busy_cnt = 0;
    always @(posedge clock) busy_cnt <= tx_start ? BYTE_CYC : (busy_cnt > 0 ? busy_cnt - 1 : 0);
    assign tx_busy = hold || busy_cnt != 0;

    logic [7:0] q_b[$];
    int         q_t[$];
    int         ovr = 0;
    always @(negedge clock) begin
        if (tx_start) begin
            q_b.push_back(tx_data);
            q_t.push_back(cyc);
        end
        if (overrun) ovr++;
    end

    typedef struct {
        logic [7:0] addr, cmd, hdr, pay;
    } vec_t;
    vec_t vecs[13];

    int n_vec = 0, n_bad = 0, rd = 0, cmd_cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clock);
        rx_valid = 1'b0;
        cmd_cyc  = cyc;
    endtask

    task automatic send_req(input logic [7:0] a, input logic [7:0] c);
        send(a);
        send(c);
    endtask

    task automatic load(input int c, input logic [39:0] f);
        @(negedge clock);
        sens_frame[40*c +: 40] = f;
        sens_valid[c] = 1'b1;
        @(negedge clock);
        sens_valid = '0;
    endtask

    task automatic get_resp(input string nm, output logic [7:0] h, output logic [7:0] p, output int th);
        int n = 0;
        while (q_b.size() - rd < 2 && n < 20000) begin
            @(negedge clock);
            n++;
        end
        if (q_b.size() - rd < 2) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: timeout, got %0d bytes, expected 2", nm, q_b.size() - rd);
            h = '0;
            p = '0;
            th = 0;
        end else begin
            h  = q_b[rd];
            p  = q_b[rd+1];
            th = q_t[rd];
            rd += 2;
        end
    endtask

    task automatic expect_resp(input string nm, input logic [7:0] eh, input logic [7:0] ep);
        logic [7:0] h, p;
        int t;
        get_resp(nm, h, p, t);
        chk({nm, "_hdr"}, int'(h), int'(eh));
        chk({nm, "_pay"}, int'(p), int'(ep));
    endtask

    initial begin
        logic [7:0] h, p;
        int t, t1, t2, o0, n;
        vecs[0]  = '{8'h01, 8'h03, 8'h03, 8'h00};
        vecs[1]  = '{8'h01, 8'h04, 8'h04, 8'h19};
        vecs[2]  = '{8'h02, 8'h05, 8'h05, 8'hFF};
        vecs[3]  = '{8'h02, 8'h03, 8'h03, 8'h1F};
        vecs[4]  = '{8'h03, 8'h03, 8'h03, 8'h1F};
        vecs[5]  = '{8'h05, 8'h03, 8'hEF, 8'h05};
        vecs[6]  = '{8'h00, 8'h99, 8'hCF, 8'h99};
        vecs[7]  = '{8'h00, 8'h05, 8'h05, 8'h40};
        vecs[8]  = '{8'h00, 8'h04, 8'h04, 8'h1A};
        vecs[9]  = '{8'h01, 8'h05, 8'h05, 8'h37};
        vecs[10] = '{8'h03, 8'h04, 8'h04, 8'hFF};
        vecs[11] = '{8'h01, 8'h08, 8'h08, 8'h00};
        vecs[12] = '{8'h04, 8'h06, 8'hEF, 8'h04};

        repeat (3) @(negedge clock);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_stream_on", int'(stream_on), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset = 1'b0;

        load(1, 40'h37_00_19_00_50);
        load(2, 40'h37_00_19_00_51);
        load(0, 40'h40_05_1A_03_62);

        for (int i = 0; i < 13; i++) begin
            send_req(vecs[i].addr, vecs[i].cmd);
            get_resp($sformatf("v%0d", i), h, p, t);
            chk($sformatf("v%0d_hdr", i), int'(h), int'(vecs[i].hdr));
            chk($sformatf("v%0d_pay", i), int'(p), int'(vecs[i].pay));
            chk($sformatf("v%0d_latency_ge2", i), int'(t - cmd_cyc >= 2), 1);
        end
        chk("bad_addr_no_stream", int'(stream_on), 0);

        send_req(8'h01, 8'h06);
        expect_resp("stream_ack", 8'h06, 8'h01);
        chk("stream_on_set", int'(stream_on), 1);
        get_resp("tick1", h, p, t1);
        chk("tick1_hdr", int'(h), 8'h06);
        chk("tick1_pay", int'(p), 8'h19);
        get_resp("tick2", h, p, t2);
        chk("tick2_hdr", int'(h), 8'h06);
        chk("tick2_pay", int'(p), 8'h19);
        chk("tick_period", t2 - t1, PERIOD);
        send_req(8'h01, 8'h08);
        expect_resp("stop_ack", 8'h08, 8'h00);
        chk("stream_on_clr", int'(stream_on), 0);
        repeat (2 * PERIOD + 500) @(negedge clock);
        chk("no_ticks_after_stop", q_b.size() - rd, 0);

        send(8'h02);
        repeat (TMO + 100) @(negedge clock);
        send_req(8'h01, 8'h04);
        expect_resp("after_timeout", 8'h04, 8'h19);
        repeat (200) @(negedge clock);
        chk("timeout_single_resp", q_b.size() - rd, 0);

        o0   = ovr;
        hold = 1'b1;
        send_req(8'h01, 8'h03);
        send_req(8'h01, 8'h04);
        send_req(8'h02, 8'h03);
        repeat (20) @(negedge clock);
        chk("overrun_pulses", ovr - o0, 1);
        chk("held_no_tx", q_b.size() - rd, 0);
        hold = 1'b0;
        expect_resp("ovr_first", 8'h03, 8'h00);
        expect_resp("ovr_second", 8'h04, 8'h19);
        repeat (300) @(negedge clock);
        chk("ovr_only_two", q_b.size() - rd, 0);

        send_req(8'h01, 8'h03);
        n = 0;
        while (q_b.size() - rd < 1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("midreset_hdr_seen", q_b.size() - rd, 1);
        reset = 1'b1;
        #1;
        chk("midreset_tx_start", int'(tx_start), 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (200) @(negedge clock);
        chk("midreset_no_more_tx", q_b.size() - rd, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
